excompress: RTL

EXCOMPRESS -- requirements
Module: excompress

---
 rtl/excompress_if.sv | 21 ++
 rtl/excompress.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/excompress_if.sv
// Handshake bundle between the uncompressed word source, the compressor and the
// downstream consumer of compressed words.
interface excompress_if;
   logic        i_stb;
   logic        o_busy;
   logic [34:0] i_word;
   logic        o_stb;
   logic        i_busy;
   logic [34:0] o_word;
   logic        o_active;

   modport master (
      output i_stb, i_word, i_busy,
      input  o_busy, o_stb, o_word, o_active
   );

   modport slave (
      input  i_stb, i_word, i_busy,
      output o_busy, o_stb, o_word, o_active
   );
endinterface

// File: rtl/excompress.sv
// Debug-bus word compressor: shortens addresses against a running reference and
// writes against an 8-entry history mirroring the receiver's table.
module excompress #(
   parameter bit OPT_LOWPOWER = 1'b0
) (
   input logic         i_clk,
   input logic         i_reset_n,
   excompress_if.slave bus
);

   typedef logic [7:0][31:0] hist_t;

   logic        stb_q, stb_d;
   logic [34:0] word_q, word_d;
   logic [29:0] ref_addr_q, ref_addr_d;
   logic        ref_inc_q, ref_inc_d;
   logic        ref_valid_q, ref_valid_d;
   hist_t       hist_q, hist_d;
   logic [3:0]  nvalid_q, nvalid_d;

   logic        busy, accept;
   logic [29:0] a, d;
   logic [31:0] data;
   logic [11:0] count, cnt_m1, cnt_m17;
   logic        hit;
   logic [2:0]  hit_k;
   logic        d_s2, a_s7, d_s7, a_s14, d_s14, w_s9, w_s16;
   logic [34:0] enc;

   assign busy         = stb_q && bus.i_busy;
   assign accept       = bus.i_stb && !busy;
   assign bus.o_busy   = busy;
   assign bus.o_stb    = stb_q;
   assign bus.o_active = stb_q;
   assign bus.o_word   = (OPT_LOWPOWER && !stb_q) ? 35'd0 : word_q;

   assign a    = bus.i_word[31:2];
   assign d    = a - ref_addr_q;
   assign data = bus.i_word[31:0];

   // A field fits an N-bit signed range when every bit above N-1 equals the sign.
   assign d_s2  = (&d[29:1])  || !(|d[29:1]);
   assign a_s7  = (&a[29:6])  || !(|a[29:6]);
   assign d_s7  = (&d[29:6])  || !(|d[29:6]);
   assign a_s14 = (&a[29:13]) || !(|a[29:13]);
   assign d_s14 = (&d[29:13]) || !(|d[29:13]);
   assign w_s9  = (&data[31:8])  || !(|data[31:8]);
   assign w_s16 = (&data[31:15]) || !(|data[31:15]);

   always_comb begin
      count = bus.i_word[11:0];
      if (count == 12'd0) begin
         count = 12'd1;
      end else if (count > 12'd2064) begin
         count = 12'd2064;
      end
      cnt_m1  = count - 12'd1;
      cnt_m17 = count - 12'd17;
   end

   // Walk from oldest to newest so the smallest matching index wins.
   always_comb begin
      hit   = 1'b0;
      hit_k = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if ((4'(k) < nvalid_q) && (hist_q[k] == data)) begin
            hit   = 1'b1;
            hit_k = 3'(k);
         end
      end
   end

   always_comb begin
      enc         = 35'd0;
      stb_d       = stb_q;
      word_d      = word_q;
      ref_addr_d  = ref_addr_q;
      ref_inc_d   = ref_inc_q;
      ref_valid_d = ref_valid_q;
      hist_d      = hist_q;
      nvalid_d    = nvalid_q;

      unique case (bus.i_word[34:33])
         2'b00: begin
            if (ref_valid_q && d_s2) begin
               enc = {4'b0010, d[1:0], bus.i_word[0], 28'd0};
            end else if (a_s7) begin
               enc = {6'b001100, a[6:0], bus.i_word[0], 21'd0};
            end else if (ref_valid_q && d_s7) begin
               enc = {6'b001101, d[6:0], bus.i_word[0], 21'd0};
            end else if (a_s14) begin
               enc = {6'b001110, a[13:0], bus.i_word[0], 14'd0};
            end else if (ref_valid_q && d_s14) begin
               enc = {6'b001111, d[13:0], bus.i_word[0], 14'd0};
            end else begin
               enc = {bus.i_word[34:2], 1'b0, bus.i_word[0]};
            end
         end
         2'b01: begin
            if (hit && !hit_k[2]) begin
               enc = {5'b01100, hit_k[1:0], 28'd0};
            end else if (w_s9) begin
               enc = {5'b01110, data[8:0], 21'd0};
            end else if (hit) begin
               enc = {5'b01101, 6'd0, hit_k, 21'd0};
            end else if (w_s16) begin
               enc = {5'b01111, data[15:0], 14'd0};
            end else begin
               enc = {3'b010, data};
            end
         end
         2'b10: begin
            if (count <= 12'd16) begin
               enc = {3'b100, cnt_m1[3:0], 28'd0};
            end else begin
               enc = {3'b101, cnt_m17[10:0], 21'd0};
            end
         end
         2'b11: enc = {bus.i_word[34:28], 28'd0};
      endcase

      if (accept) begin
         stb_d  = 1'b1;
         word_d = enc;
         unique case (bus.i_word[34:33])
            2'b00: begin
               ref_addr_d  = a;
               ref_inc_d   = bus.i_word[0];
               ref_valid_d = 1'b1;
            end
            2'b01: begin
               ref_addr_d = ref_addr_q + {29'd0, ref_inc_q};
               // Only forms the receiver can't resolve from its table get inserted.
               if (!hit && !w_s9) begin
                  hist_d = {hist_q[6:0], data};
                  if (nvalid_q != 4'd8) begin
                     nvalid_d = nvalid_q + 4'd1;
                  end
               end
            end
            2'b10: ref_addr_d = ref_addr_q + (ref_inc_q ? {18'd0, count} : 30'd0);
            2'b11: ref_valid_d = 1'b0;
         endcase
      end else if (!bus.i_busy) begin
         stb_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         stb_q       <= 1'b0;
         word_q      <= 35'd0;
         ref_addr_q  <= 30'd0;
         ref_inc_q   <= 1'b0;
         ref_valid_q <= 1'b0;
         hist_q      <= '0;
         nvalid_q    <= 4'd0;
      end else begin
         stb_q       <= stb_d;
         word_q      <= word_d;
         ref_addr_q  <= ref_addr_d;
         ref_inc_q   <= ref_inc_d;
         ref_valid_q <= ref_valid_d;
         hist_q      <= hist_d;
         nvalid_q    <= nvalid_d;
      end
   end

endmodule
